// File: rtl/ysyx_22050019_clint_pkg.sv
// Shared CLINT address map, decode/response encodings and the byte-merge helper.
package ysyx_22050019_clint_pkg;

    localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
    localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;
    localparam logic [63:0] CLINT_BASE         = 64'h0000_0000_0200_0000;

    typedef enum logic [1:0] {
        SEL_NONE     = 2'd0,
        SEL_MSIP     = 2'd1,
        SEL_MTIMECMP = 2'd2,
        SEL_MTIME    = 2'd3
    } clint_sel_e;

    typedef enum logic {
        RSP_IDLE = 1'b0,
        RSP_BUSY = 1'b1
    } rsp_state_e;

    // Byte i of the result comes from new_val when mask[i] is set, else from old_val.
    function automatic logic [63:0] byte_merge(input logic [63:0] old_val,
                                               input logic [63:0] new_val,
                                               input logic [7:0]  mask);
        logic [63:0] res;
        res = old_val;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                res[i*8 +: 8] = new_val[i*8 +: 8];
            end else begin
                res[i*8 +: 8] = old_val[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ysyx_22050019_clint_timer.sv
// Prescaler, mtime/mtimecmp registers with byte-masked writes, and the timer compare.
module ysyx_22050019_clint_timer
    import ysyx_22050019_clint_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mtime_we,
    input  logic        mtimecmp_we,
    input  logic [63:0] wdata,
    input  logic [7:0]  wmask,
    output logic [63:0] mtime,
    output logic [63:0] mtimecmp,
    output logic        timer_irq
);

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    logic [15:0] presc_r;
    logic [63:0] mtime_r;
    logic [63:0] mtimecmp_r;
    logic        timer_irq_r;
    logic        tick_s;
    logic [63:0] mtime_inc_s;

    assign tick_s      = (presc_r == TICK_LAST);
    // A write landing on a tick merges onto the incremented value, so unmasked bytes still advance.
    assign mtime_inc_s = tick_s ? (mtime_r + 64'd1) : mtime_r;

    // Timer state: prescaler, mtime, mtimecmp and the one-cycle-lagged compare.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            presc_r     <= 16'd0;
            mtime_r     <= 64'd0;
            mtimecmp_r  <= 64'hFFFF_FFFF_FFFF_FFFF;
            timer_irq_r <= 1'b0;
        end else begin
            presc_r     <= tick_s ? 16'd0 : (presc_r + 16'd1);
            mtime_r     <= mtime_we ? byte_merge(mtime_inc_s, wdata, wmask) : mtime_inc_s;
            mtimecmp_r  <= mtimecmp_we ? byte_merge(mtimecmp_r, wdata, wmask) : mtimecmp_r;
            timer_irq_r <= (mtime_r >= mtimecmp_r);
        end
    end

    assign mtime     = mtime_r;
    assign mtimecmp  = mtimecmp_r;
    assign timer_irq = timer_irq_r;

endmodule

// File: rtl/ysyx_22050019_clint.sv
// Core-local interruptor: address decode, valid/ready handshake and registered response.
module ysyx_22050019_clint
    import ysyx_22050019_clint_pkg::*;
#(
    parameter int          TICK_DIV  = 1,
    parameter logic [63:0] BASE_ADDR = CLINT_BASE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic        soft_irq,
    output logic        timer_irq
);

    clint_sel_e  sel_s;
    rsp_state_e  state_r;
    rsp_state_e  state_next_s;
    logic        err_s;
    logic        accept_s;
    logic        wr_ok_s;
    logic        rsp_valid_s;
    logic        req_ready_s;
    logic [63:0] rd_val_s;
    logic [63:0] rdata_r;
    logic        err_r;
    logic        msip_r;
    logic [63:0] mtime_s;
    logic [63:0] mtimecmp_s;

    // Address decode: page match, 8-byte alignment, then one of the three offsets.
    always_comb begin
        sel_s = SEL_NONE;
        if ((req_addr[63:16] == BASE_ADDR[63:16]) && (req_addr[2:0] == 3'd0)) begin
            case (req_addr[15:0])
                CLINT_MSIP_OFF:     sel_s = SEL_MSIP;
                CLINT_MTIMECMP_OFF: sel_s = SEL_MTIMECMP;
                CLINT_MTIME_OFF:    sel_s = SEL_MTIME;
                default:            sel_s = SEL_NONE;
            endcase
        end else begin
            sel_s = SEL_NONE;
        end
    end

    assign err_s    = (sel_s == SEL_NONE);
    assign accept_s = req_valid && req_ready_s;
    assign wr_ok_s  = accept_s && req_wen && !err_s;

    // Read data mux; writes and errors return zero.
    always_comb begin
        rd_val_s = 64'd0;
        if (req_wen) begin
            rd_val_s = 64'd0;
        end else begin
            case (sel_s)
                SEL_MSIP:     rd_val_s = {63'd0, msip_r};
                SEL_MTIMECMP: rd_val_s = mtimecmp_s;
                SEL_MTIME:    rd_val_s = mtime_s;
                default:      rd_val_s = 64'd0;
            endcase
        end
    end

    // Response state and held payload; payload only changes on acceptance.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_r <= RSP_IDLE;
            rdata_r <= 64'd0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                rdata_r <= rd_val_s;
                err_r   <= err_s;
            end else begin
                rdata_r <= rdata_r;
                err_r   <= err_r;
            end
        end
    end

    // Response next-state: a new acceptance refills the holding register in place.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            RSP_IDLE: begin
                if (accept_s) begin
                    state_next_s = RSP_BUSY;
                end else begin
                    state_next_s = RSP_IDLE;
                end
            end
            RSP_BUSY: begin
                if (accept_s) begin
                    state_next_s = RSP_BUSY;
                end else if (rsp_ready) begin
                    state_next_s = RSP_IDLE;
                end else begin
                    state_next_s = RSP_BUSY;
                end
            end
            default: state_next_s = RSP_IDLE;
        endcase
    end

    // Handshake outputs derived from the response state.
    always_comb begin
        rsp_valid_s = (state_r == RSP_BUSY);
        req_ready_s = !rsp_valid_s || rsp_ready;
    end

    // Software interrupt pending bit; only byte 0 bit 0 is stored.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            msip_r <= 1'b0;
        end else if (wr_ok_s && (sel_s == SEL_MSIP) && req_wmask[0]) begin
            msip_r <= req_wdata[0];
        end else begin
            msip_r <= msip_r;
        end
    end

    ysyx_22050019_clint_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .mtime_we    (wr_ok_s && (sel_s == SEL_MTIME)),
        .mtimecmp_we (wr_ok_s && (sel_s == SEL_MTIMECMP)),
        .wdata       (req_wdata),
        .wmask       (req_wmask),
        .mtime       (mtime_s),
        .mtimecmp    (mtimecmp_s),
        .timer_irq   (timer_irq)
    );

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_s;
    assign rsp_rdata = rdata_r;
    assign rsp_err   = err_r;
    assign soft_irq  = msip_r;

endmodule

// File: tb/tb_ysyx_22050019_clint.sv
// Bench for the CLINT: two instances (TICK_DIV 1 and 4) checked every cycle against a behavioural model.
module tb_ysyx_22050019_clint;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid[2], req_ready[2], req_wen[2], rsp_valid[2], rsp_ready[2];
    logic        rsp_err[2], soft_irq[2], timer_irq[2];
    logic [63:0] req_addr[2], req_wdata[2], rsp_rdata[2];
    logic [7:0]  req_wmask[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ysyx_22050019_clint #(
            .TICK_DIV  ((g == 0) ? 1 : 4),
            .BASE_ADDR (64'h0000_0000_0200_0000)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_wen   (req_wen[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_wmask (req_wmask[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g]),
            .soft_irq  (soft_irq[g]),
            .timer_irq (timer_irq[g])
        );
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model: architectural register contents and the expected response holder.
    logic [63:0] m_mtime[2], m_cmp[2], m_rdata[2];
    logic        m_msip[2], m_irq[2], m_rv[2], m_err[2];
    int          m_presc[2];
    logic        acc[2];

    typedef struct packed {
        logic        wen;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] exp_rdata;
        logic        exp_err;
        logic        exp_soft;
    } vec_t;

    vec_t        vecs[15];
    logic [63:0] addrs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n, input logic [7:0] m);
        logic [63:0] r;
        r = o;
        for (int b = 0; b < 8; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // Advance the model of DUT i across one rising edge, given the inputs currently driven.
    task automatic model_update(input int i);
        logic [63:0] nxt_time, rd;
        logic        e;
        int          div;
        div      = (i == 0) ? 1 : 4;
        acc[i]   = req_valid[i] && (!m_rv[i] || rsp_ready[i]);
        nxt_time = m_mtime[i] + ((m_presc[i] == div - 1) ? 64'd1 : 64'd0);
        m_presc[i] = (m_presc[i] + 1) % div;
        m_irq[i] = (m_mtime[i] >= m_cmp[i]);
        if (acc[i]) begin
            e  = 1'b1;
            rd = 64'd0;
            if (req_addr[i][63:16] == 48'h0000_0000_0200 && req_addr[i][2:0] == 3'd0) begin
                case (req_addr[i][15:0])
                    16'h0000: begin
                        e  = 1'b0;
                        rd = {63'd0, m_msip[i]};
                        if (req_wen[i] && req_wmask[i][0]) m_msip[i] = req_wdata[i][0];
                    end
                    16'h4000: begin
                        e  = 1'b0;
                        rd = m_cmp[i];
                        if (req_wen[i]) m_cmp[i] = merge(m_cmp[i], req_wdata[i], req_wmask[i]);
                    end
                    16'hBFF8: begin
                        e  = 1'b0;
                        rd = m_mtime[i];
                        if (req_wen[i]) nxt_time = merge(nxt_time, req_wdata[i], req_wmask[i]);
                    end
                    default: e = 1'b1;
                endcase
            end
            if (req_wen[i] || e) rd = 64'd0;
            m_rv[i]    = 1'b1;
            m_rdata[i] = rd;
            m_err[i]   = e;
        end else if (rsp_ready[i]) begin
            m_rv[i] = 1'b0;
        end
        m_mtime[i] = nxt_time;
    endtask

    // One clock: compare every DUT output with the model, update the model, move to the next negedge.
    task automatic step();
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("d%0d_req_ready", i), req_ready[i], !m_rv[i] || rsp_ready[i]);
            chk($sformatf("d%0d_rsp_valid", i), rsp_valid[i], m_rv[i]);
            if (m_rv[i]) begin
                chk($sformatf("d%0d_rsp_rdata", i), rsp_rdata[i], m_rdata[i]);
                chk($sformatf("d%0d_rsp_err", i), rsp_err[i], m_err[i]);
            end
            chk($sformatf("d%0d_soft_irq", i), soft_irq[i], m_msip[i]);
            chk($sformatf("d%0d_timer_irq", i), timer_irq[i], m_irq[i]);
            model_update(i);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle();
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_wen[i]   = 1'b0;
            req_addr[i]  = 64'd0;
            req_wdata[i] = 64'd0;
            req_wmask[i] = 8'd0;
            rsp_ready[i] = 1'b1;
        end
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            m_mtime[i] = 64'd0;
            m_cmp[i]   = 64'hFFFF_FFFF_FFFF_FFFF;
            m_msip[i]  = 1'b0;
            m_irq[i]   = 1'b0;
            m_rv[i]    = 1'b0;
            m_rdata[i] = 64'd0;
            m_err[i]   = 1'b0;
            m_presc[i] = 0;
            acc[i]     = 1'b0;
        end
        rst_n = 1'b0;
        cyc   = 0;
    endtask

    // Single transaction with rsp_ready held high; returns the response and the accept cycle.
    task automatic xact(input int id, input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] wmask, output logic [63:0] rdata, output logic err,
                        output int acc_cyc);
        req_valid[id] = 1'b1;
        req_wen[id]   = wen;
        req_addr[id]  = addr;
        req_wdata[id] = wdata;
        req_wmask[id] = wmask;
        rsp_ready[id] = 1'b1;
        acc_cyc = -1;
        for (int n = 0; n < 20; n++) begin
            acc_cyc = cyc;
            step();
            if (acc[id]) break;
        end
        if (!acc[id]) begin
            checks++;
            failures++;
            $display("FAIL xact_accept_timeout: dut %0d addr %h never accepted", id, addr);
        end
        req_valid[id] = 1'b0;
        #1;
        rdata = rsp_rdata[id];
        err   = rsp_err[id];
        step();
    endtask

    initial begin
        logic [63:0] rd, r1, r2, r3, held;
        logic        er;
        int          a1, a2, a3, w, cnt;

        addrs = '{64'h0200_0000, 64'h0200_4000, 64'h0200_BFF8, 64'h0200_0008,
                  64'h0200_4004, 64'h0200_1000, 64'h1_0200_4000};
        //          wen   addr             wdata                   wmask  exp_rdata               err   soft
        vecs[0]  = '{1'b1, 64'h0200_0000,   64'h3,                  8'h01, 64'h0,                  1'b0, 1'b1};
        vecs[1]  = '{1'b0, 64'h0200_0000,   64'h0,                  8'h00, 64'h1,                  1'b0, 1'b1};
        vecs[2]  = '{1'b1, 64'h0200_4000,   64'h1122_3344_5566_7788, 8'h0F, 64'h0,                 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 64'h0200_4000,   64'h0,                  8'h00, 64'hFFFF_FFFF_5566_7788, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 64'h0200_4000,   64'h0,                  8'h00, 64'h0,                  1'b0, 1'b1};
        vecs[5]  = '{1'b0, 64'h0200_4000,   64'h0,                  8'h00, 64'hFFFF_FFFF_5566_7788, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 64'h0200_0008,   64'h0,                  8'h00, 64'h0,                  1'b1, 1'b1};
        vecs[7]  = '{1'b0, 64'h0200_4004,   64'h0,                  8'h00, 64'h0,                  1'b1, 1'b1};
        vecs[8]  = '{1'b1, 64'h0200_1000,   64'h0,                  8'hFF, 64'h0,                  1'b1, 1'b1};
        vecs[9]  = '{1'b1, 64'h1_0200_4000, 64'h0,                  8'hFF, 64'h0,                  1'b1, 1'b1};
        vecs[10] = '{1'b0, 64'h0200_BFFC,   64'h0,                  8'h00, 64'h0,                  1'b1, 1'b1};
        vecs[11] = '{1'b0, 64'h0200_4000,   64'h0,                  8'h00, 64'hFFFF_FFFF_5566_7788, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 64'h0200_0000,   64'h0,                  8'h00, 64'h1,                  1'b0, 1'b1};
        vecs[13] = '{1'b1, 64'h0200_0000,   64'h0,                  8'hFF, 64'h0,                  1'b0, 1'b0};
        vecs[14] = '{1'b0, 64'h0200_0000,   64'h0,                  8'h00, 64'h0,                  1'b0, 1'b0};

        do_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst%0d_rsp_valid", i), rsp_valid[i], 1'b0);
            chk($sformatf("rst%0d_rsp_rdata", i), rsp_rdata[i], 64'd0);
            chk($sformatf("rst%0d_rsp_err", i), rsp_err[i], 1'b0);
            chk($sformatf("rst%0d_soft_irq", i), soft_irq[i], 1'b0);
            chk($sformatf("rst%0d_timer_irq", i), timer_irq[i], 1'b0);
        end

        // mtime counts cycles since reset at TICK_DIV=1; mtimecmp resets to all ones
        xact(0, 1'b0, 64'h0200_BFF8, 64'd0, 8'h00, rd, er, a1);
        chk("mtime_after_reset", rd, 64'(a1));
        chk("mtime_read_err", er, 1'b0);
        xact(0, 1'b0, 64'h0200_4000, 64'd0, 8'h00, rd, er, a1);
        chk("mtimecmp_after_reset", rd, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("irq_idle", timer_irq[0], 1'b0);

        // Timer interrupt: first visible one cycle after mtime reaches 20
        xact(0, 1'b1, 64'h0200_4000, 64'd20, 8'hFF, rd, er, a1);
        for (int n = 0; n < 60 && timer_irq[0] !== 1'b1; n++) step();
        chk("irq_rise_cycle", 64'(cyc), 64'd21);
        repeat (3) step();
        chk("irq_held", timer_irq[0], 1'b1);
        req_valid[0] = 1'b1; req_wen[0] = 1'b1; req_addr[0] = 64'h0200_4000;
        req_wdata[0] = 64'hFFFF_FFFF_FFFF_FFFF; req_wmask[0] = 8'hFF;
        step();
        req_valid[0] = 1'b0;
        chk("irq_one_after_cmp_write", timer_irq[0], 1'b1);
        step();
        chk("irq_drop_two_after", timer_irq[0], 1'b0);

        for (int v = 0; v < 15; v++) begin
            xact(0, vecs[v].wen, vecs[v].addr, vecs[v].wdata, vecs[v].wmask, rd, er, a1);
            chk($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
            chk($sformatf("vec%0d_err", v), er, vecs[v].exp_err);
            chk($sformatf("vec%0d_soft_irq", v), soft_irq[0], vecs[v].exp_soft);
        end

        // Back-pressure: first read held for 3 cycles, second read only accepted on release
        req_valid[0] = 1'b1; req_wen[0] = 1'b0; req_addr[0] = 64'h0200_4000; rsp_ready[0] = 1'b0;
        step();
        req_addr[0] = 64'h0200_0000;
        #1;
        held = rsp_rdata[0];
        chk("bp_first_rdata", held, 64'hFFFF_FFFF_5566_7788);
        repeat (3) begin
            chk("bp_req_ready_low", req_ready[0], 1'b0);
            chk("bp_rdata_stable", rsp_rdata[0], held);
            step();
        end
        rsp_ready[0] = 1'b1;
        step();
        req_valid[0] = 1'b0;
        #1;
        chk("bp_second_valid", rsp_valid[0], 1'b1);
        chk("bp_second_rdata", rsp_rdata[0], 64'd0);
        step();

        // TICK_DIV=4: 16 cycles advance mtime by 4, then wrap from all ones
        xact(1, 1'b0, 64'h0200_BFF8, 64'd0, 8'h00, r1, er, a1);
        chk("d1_mtime_a", r1, 64'(a1 / 4));
        repeat (14) step();
        xact(1, 1'b0, 64'h0200_BFF8, 64'd0, 8'h00, r2, er, a2);
        chk("d1_mtime_b", r2, 64'(a2 / 4));
        chk("d1_delta16", r2 - r1, 64'd4);
        xact(1, 1'b1, 64'h0200_BFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd, er, w);
        repeat (3) step();
        xact(1, 1'b0, 64'h0200_BFF8, 64'd0, 8'h00, r3, er, a3);
        cnt = 0;
        for (int t = w + 1; t < a3; t++) if (t % 4 == 3) cnt++;
        chk("d1_wrap", r3, 64'(cnt - 1));

        // Reset while a response is pending drops it
        req_valid[0] = 1'b1; req_wen[0] = 1'b0; req_addr[0] = 64'h0200_4000; rsp_ready[0] = 1'b0;
        step();
        do_reset();
        #1;
        chk("midrst_rsp_valid", rsp_valid[0], 1'b0);
        chk("midrst_rsp_rdata", rsp_rdata[0], 64'd0);

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                req_valid[i] = ($urandom_range(0, 9) < 7);
                req_wen[i]   = 1'($urandom_range(0, 1));
                req_addr[i]  = addrs[$urandom_range(0, 6)];
                req_wdata[i] = {$urandom, $urandom};
                if (req_addr[i] == 64'h0200_4000 && $urandom_range(0, 1) == 1)
                    req_wdata[i] = m_mtime[i] + 64'($urandom_range(0, 12));
                case ($urandom_range(0, 3))
                    0:       req_wmask[i] = 8'hFF;
                    1:       req_wmask[i] = 8'h00;
                    2:       req_wmask[i] = 8'h01;
                    default: req_wmask[i] = 8'($urandom);
                endcase
                rsp_ready[i] = ($urandom_range(0, 3) != 0);
            end
            step();
        end
        idle();
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_22050019_clint.md
Name: ysyx_22050019_clint

Overview:
Core-local interruptor for the NPC core. It holds the memory-mapped msip, mtimecmp and mtime registers behind a single-outstanding valid/ready bus port. It drives the soft and timer interrupt-pending lines, which feed the CSR block's mip.MSIP and mip.MTIP bits. The CSR block and trap logic consume these lines to raise interrupts.

Parameters:
TICK_DIV, 1, clk cycles per mtime increment; legal range 1..65535.
BASE_ADDR, 64'h0000_0000_0200_0000, CLINT base; only req_addr[15:0] is decoded when req_addr[63:16] matches BASE_ADDR[63:16].

Ports:
clk  in  1  core clock
rst_n  in  1  reset; synchronous, active-high (the name is historical; asserted = 1)
req_valid  in  1  bus request valid
req_ready  out  1  block can accept a request
req_wen  in  1  1 = write, 0 = read
req_addr  in  64  byte address, 8-byte aligned
req_wdata  in  64  write data
req_wmask  in  8  byte-enable mask for writes
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts the response
rsp_rdata  out  64  read data; 0 on writes and on errors
rsp_err  out  1  unmapped address or misaligned access
soft_irq  out  1  msip[0]
timer_irq  out  1  registered (mtime >= mtimecmp)

Behaviour:
- Reset (rst_n=1 at a clk edge):
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, soft_irq=0, timer_irq=0.
  - Reset mid-transaction drops any pending response; nothing is replayed.
- Register map (offsets from BASE_ADDR):
  - 0x0000: msip. Only bit 0 is stored; other bits read 0.
  - 0x4000: mtimecmp, 64-bit.
  - 0xBFF8: mtime, 64-bit.
- Handshake:
  - req_ready = !rsp_valid || rsp_ready.
  - A request is accepted on a cycle with req_valid && req_ready.
  - The response is registered: rsp_valid rises the cycle after acceptance.
  - rsp_valid, rsp_rdata and rsp_err hold stable until rsp_valid && rsp_ready.
  - Back-to-back requests with rsp_ready=1 give one response per cycle.
- Reads: rsp_rdata returns the register value sampled in the accept cycle, before that cycle's tick increment.
- Writes:
  - Byte-masked: byte i is updated when req_wmask[i]=1.
  - wmask=0 is a legal no-op write and returns rsp_err=0.
  - Writes take effect at the accept edge.
- Errors:
  - Condition: req_addr[2:0]!=0, or the upper address bits do not match, or the offset is not one of the three mapped offsets.
  - Result: rsp_err=1, rsp_rdata=0, no state change.
- Prescaler and mtime:
  - The prescaler counts 0..TICK_DIV-1.
  - On the cycle it equals TICK_DIV-1 it wraps to 0 and mtime increments by 1.
  - TICK_DIV=1 increments mtime every cycle.
  - mtime wraps from 2^64-1 to 0 with no flag.
- Tick and write in the same cycle:
  - Unmasked bytes take the value mtime+1.
  - Masked bytes take the written data.
  - The prescaler is not reset by mtime writes.
- Interrupt lines:
  - timer_irq <= (mtime_q >= mtimecmp_q) every cycle, as an unsigned 64-bit compare on the current registered values, so it lags register updates by one cycle.
  - Writing mtimecmp above mtime deasserts timer_irq two cycles after acceptance.
  - soft_irq is msip[0] directly, with no additional latency beyond the register.
- No internal FSM beyond the response holding register: states are IDLE (rsp_valid=0) and RESP (rsp_valid=1).

Decomposition:
- Shared package/header: CLINT_MSIP_OFF, CLINT_MTIMECMP_OFF, CLINT_MTIME_OFF, CLINT_BASE, placed next to the existing CSR address defines.
- Sub-module ysyx_22050019_clint_timer: prescaler, mtime counter, byte-merge write and compare.
- The top level handles decode, the handshake and the response register.

Test Plan:
- Reset then read 0xBFF8 and 0x4000 with TICK_DIV=1 → rsp_rdata=mtime at the accept cycle (small count), then 64'hFFFF_FFFF_FFFF_FFFF; timer_irq=0, rsp_err=0.
- Write mtimecmp=20 with wmask=8'hFF while mtime<20 → timer_irq=0 until mtime_q reaches 20, asserted 1 cycle later and held; then write mtimecmp=64'hFFFF_FFFF_FFFF_FFFF → timer_irq=0 two cycles after acceptance.
- TICK_DIV=4: observe 16 cycles → mtime advances by exactly 4. Write mtime=64'hFFFF_FFFF_FFFF_FFFF → mtime reads 0 after the next tick.
- Write msip wdata=64'h3, mask=8'h01 → soft_irq=1 the next cycle and readback=1. Write 0 → soft_irq=0.
- Hold rsp_ready=0 for 3 cycles with a read pending → req_ready=0 and rsp_rdata stable; a second request is accepted only on the release cycle.
- Read offset 0x0008, read misaligned 0x4004, and write 0x1000 → rsp_err=1 and rsp_rdata=0 for each; all registers unchanged.
